wb_sram_slave: RTL and testbench
================================

WB_SRAM_SLAVE -- requirements
Module: wb_sram_slave

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 32, data width; must be a multiple of 8.
REQ-003 SHALL have parameter MEM_WORDS, default 1024, memory depth in words; must be a power of 2.
REQ-004 SHALL have parameter WAIT_STATES, default 0, extra cycles before the first ACK of a cycle; range 0..15.
REQ-005 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-006 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port s  wb_if.slave  (ADR, CTI, BTE, DAT_W, SEL, CYC, STB, WE in; DAT_R, ACK, ERR out)  Wishbone target port.

Function
REQ-008 SHALL index the memory by word = ADR[log2(MEM_WORDS)+log2(WB_DATA_WIDTH/8)-1 : log2(WB_DATA_WIDTH/8)]; upper address bits are ignored (the interconnect decodes them).
REQ-009 SHALL implement states IDLE, WAIT, ACK, BURST, DONE, with ACK and ERR registered.
REQ-010 IDLE: on CYC&STB, SHALL load the wait counter with WAIT_STATES and go to WAIT, or to ACK if WAIT_STATES=0.
REQ-011 WAIT: SHALL decrement the counter each cycle and go to ACK when it reaches 0.
REQ-012 ACK cycle: SHALL drive ACK=1 and DAT_R=mem[word] for reads.
REQ-013 Writes SHALL commit on the clock edge that ends a cycle with ACK=1, STB=1, WE=1; only bytes with SEL[i]=1 change.
REQ-014 Classic cycle (CTI=000, 001 or 111): after the ACK cycle, SHALL go to DONE (ACK=0 for one cycle), then IDLE. Back-to-back classic accesses with WAIT_STATES=0 therefore ACK every 3rd cycle.
REQ-015 Incrementing burst (CTI=010): after the first ACK, SHALL go to BURST and assert ACK every cycle while CYC&STB and CTI=010, with zero wait states on later beats.
REQ-016 Burst address SHALL advance internally per BTE: 00 linear; 01 wrap-4; 10 wrap-8; 11 wrap-16. Wrap keeps the upper word bits and increments the low 2/3/4 bits modulo the wrap size; linear wraps modulo MEM_WORDS.
REQ-017 The burst beat acked with CTI=111 SHALL be the last; the next state is DONE.
REQ-018 STB low in BURST SHALL deassert ACK on the next cycle and return to IDLE (burst abandoned). A later STB starts a new cycle at the master's ADR.
REQ-019 CYC low in any state SHALL force IDLE next cycle with ACK=0 and ERR=0, and nothing written on that edge.
REQ-020 Reserved CTI (011..110) on the first beat SHALL produce ERR=1 in place of ACK for one cycle, with no write, then DONE.
REQ-021 ACK and ERR SHALL never both be 1.
REQ-022 DAT_R SHALL be 0 whenever ACK=0.

Reset
REQ-023 While rstn=0 at a clock edge: state=IDLE, ACK=0, ERR=0, DAT_R=0, wait counter=0, burst address=0.
REQ-024 Memory contents SHALL NOT be reset.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no write on the reset edge.

Configuration
REQ-026 Macro WB_SRAM_SLAVE_BURST_EN defined: REQ-015..REQ-018 are active.
REQ-027 Macro undefined: CTI=010 SHALL be handled as classic (REQ-014) and BTE ignored; no BURST state or address generator is compiled. REQ-020 still applies.

Structure
REQ-028 Shared package wb_pkg SHALL hold typedef wb_cti_e (CLASSIC=000, CONST=001, INCR=010, EOB=111) and typedef wb_bte_e (LINEAR, WRAP4, WRAP8, WRAP16).
REQ-029 The state typedef SHALL be local to the module.
REQ-030 Burst next-address computation SHALL be a sub-module wb_sram_slave_addr_gen (inputs: current word, BTE; output: next word), instantiated only under WB_SRAM_SLAVE_BURST_EN.

Verification
REQ-031 Classic write ADR=0x10, DAT_W=0xAABBCCDD, SEL=4'b0101, then read 0x10 from 0x11223344 -> DAT_R=0x11BB33DD; WAIT_STATES=0 gives ACK 1 cycle after STB.
REQ-032 WAIT_STATES=3, classic read -> ACK exactly 4 cycles after STB rise, one cycle wide, followed by one cycle of ACK=0.
REQ-033 Burst read CTI=010, BTE=01, ADR=0x0C (word 3), 4 beats with the last CTI=111 -> words 3,0,1,2 returned, ACK continuous for 4 cycles, then DONE.
REQ-034 Burst write, BTE=00, 8 beats starting word 0x3FE with MEM_WORDS=1024, STB low at beat 5 -> words 0x3FE,0x3FF,0x000,0x001 written; ACK drops the cycle after STB falls; later words untouched.
REQ-035 CTI=101 request -> ERR=1 for one cycle, ACK=0, memory unchanged; rstn pulsed during a burst -> ACK=0 next cycle, the in-flight beat not written.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone cycle-type and burst-type encodings.
// Used by wb_sram_slave (burst support under WB_SRAM_SLAVE_BURST_EN).
package wb_pkg;

  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    CONST   = 3'b001,
    INCR    = 3'b010,
    EOB     = 3'b111
  } wb_cti_e;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    WRAP4  = 2'b01,
    WRAP8  = 2'b10,
    WRAP16 = 2'b11
  } wb_bte_e;

  function automatic logic cti_reserved(
    input logic [2:0] cti
  );
    return !(cti inside {CLASSIC, CONST, INCR, EOB});
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 registered-feedback bus bundle.
// Slave modport used by wb_sram_slave.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic [AW-1:0]   adr;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic [DW/8-1:0] sel;
  logic            cyc;
  logic            stb;
  logic            we;
  logic            ack;
  logic            err;

  modport slave (
    input  adr, cti, bte, dat_w, sel,
    input  cyc, stb, we,
    output dat_r, ack, err
  );

  modport master (
    output adr, cti, bte, dat_w, sel,
    output cyc, stb, we,
    input  dat_r, ack, err
  );

endinterface

// File: rtl/wb_sram_slave_addr_gen.sv
// Next word address for a Wishbone incrementing burst.
// Wrap modes keep upper bits and step the low bits modulo 4/8/16.
module wb_sram_slave_addr_gen
  import wb_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0] word,
  input  logic [1:0]   bte,
  output logic [W-1:0] next_word
);

  logic [W-1:0] mask;
  logic [W-1:0] inc;

  assign inc = word + W'(1);

  always_comb begin
    mask = '1;
    unique case (bte)
      WRAP4:   mask = W'(3);
      WRAP8:   mask = W'(7);
      WRAP16:  mask = W'(15);
      default: mask = '1;
    endcase
  end

  assign next_word = (word & ~mask) | (inc & mask);

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone SRAM target, registered ACK/ERR, optional wait states.
// Define WB_SRAM_SLAVE_BURST_EN for incrementing-burst support.
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_WORDS     = 1024,
  parameter int WAIT_STATES   = 0
) (
  input logic clk,
  input logic rstn,
  wb_if.slave s
);

  localparam int NB = WB_DATA_WIDTH / 8;
  localparam int BW = $clog2(NB);
  localparam int WW = $clog2(MEM_WORDS);

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WAIT  = 3'd1;
  localparam state_t S_ACK   = 3'd2;
  localparam state_t S_DONE  = 3'd4;
`ifdef WB_SRAM_SLAVE_BURST_EN
  localparam state_t S_BURST = 3'd3;
`endif

  logic [WB_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [WB_ADDR_WIDTH-1:0] adr;
  logic [WW-1:0]            adr_word;
  state_t                   state, state_n;
  logic [3:0]               cnt, cnt_n;
  logic [WW-1:0]            word, word_n;
  logic                     ack, ack_n;
  logic                     err, err_n;
  logic [WB_DATA_WIDTH-1:0] dat_r;
  logic                     first;
  logic                     beat;
  logic                     rsv;
  logic                     wr;
  logic                     unused_bits;

  assign adr      = s.adr;
  assign adr_word = adr[WW+BW-1:BW];
  assign rsv      = cti_reserved(s.cti);

`ifdef WB_SRAM_SLAVE_BURST_EN
  logic [WW-1:0] nxt;

  wb_sram_slave_addr_gen #(
    .W(WW)
  ) u_addr_gen (
    .word      (word),
    .bte       (s.bte),
    .next_word (nxt)
  );

  assign unused_bits = ^adr;
`else
  assign unused_bits = ^{adr, s.bte};
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    word_n  = word;
    first   = 1'b0;
    beat    = 1'b0;
    if (!s.cyc) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (s.stb) begin
          word_n = adr_word;
          if (WAIT_STATES == 0) begin
            first = 1'b1;
          end else begin
            cnt_n   = 4'(WAIT_STATES);
            state_n = S_WAIT;
          end
        end
        S_WAIT: if (!s.stb) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
          first = (cnt == 4'd1);
        end
`ifdef WB_SRAM_SLAVE_BURST_EN
        S_ACK: if (ack && s.stb && s.cti == INCR) begin
          state_n = S_BURST;
          beat    = 1'b1;
          word_n  = nxt;
        end else begin
          state_n = S_DONE;
        end
        S_BURST: if (!s.stb) begin
          state_n = S_IDLE;
        end else if (s.cti == INCR) begin
          beat   = 1'b1;
          word_n = nxt;
        end else begin
          state_n = S_DONE;
        end
`else
        S_ACK:  state_n = S_DONE;
`endif
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
    if (first) state_n = S_ACK;
  end

  // Reserved cycle types answer with ERR where ACK would appear.
  assign ack_n = (first && !rsv) || beat;
  assign err_n = first && rsv;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
      word  <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      dat_r <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      word  <= word_n;
      ack   <= ack_n;
      err   <= err_n;
      dat_r <= ack_n ? mem[word_n] : '0;
    end
  end

  assign wr = rstn && ack && s.cyc && s.stb && s.we;

  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < NB; i++) begin
        if (s.sel[i]) mem[word][i*8 +: 8] <= s.dat_w[i*8 +: 8];
      end
    end
  end

  assign s.ack   = ack;
  assign s.err   = err;
  assign s.dat_r = dat_r;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed + randomized bench for wb_sram_slave (0 and 3 wait states).
// Burst checks compile only with WB_SRAM_SLAVE_BURST_EN.
module tb_wb_sram_slave;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  wb_if #(.AW(32), .DW(32)) bus0 ();
  wb_if #(.AW(32), .DW(32)) bus1 ();

  wb_sram_slave #(.WAIT_STATES(0)) dut0 (
    .clk  (clk),
    .rstn (rstn),
    .s    (bus0)
  );

  wb_sram_slave #(.WAIT_STATES(3)) dut1 (
    .clk  (clk),
    .rstn (rstn),
    .s    (bus1)
  );

  int checks = 0;
  int errors = 0;
  bit mon = 1'b0;
  logic [31:0] model [1024];

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  sl
  );
    logic [31:0] m;
    m = {{8{sl[3]}}, {8{sl[2]}}, {8{sl[1]}}, {8{sl[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  // word of beat k of a burst starting at 'start'
  function automatic int wrap_word(int start, int k, int bte);
    int size;
    int base;
    size = (bte == 0) ? 1024 : (4 << (bte - 1));
    base = start - (start % size);
    return base + ((start - base + k) % size);
  endfunction

  always @(negedge clk) begin
    if (mon) begin
      check("excl0", 32'(bus0.ack & bus0.err), 32'h0);
      check("zero0", bus0.ack ? 32'h0 : bus0.dat_r, 32'h0);
      check("excl1", 32'(bus1.ack & bus1.err), 32'h0);
      check("zero1", bus1.ack ? 32'h0 : bus1.dat_r, 32'h0);
    end
  end

  task automatic wait_ack0(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus0.ack && !bus0.err && lat < 20);
  endtask

  task automatic classic(
    input  logic        w,
    input  int          wd,
    input  logic [31:0] d,
    input  logic [3:0]  sl,
    input  logic [2:0]  ct,
    output logic [31:0] rd,
    output int          lat,
    output logic        e
  );
    bus0.adr   = 32'(wd) << 2;
    bus0.we    = w;
    bus0.dat_w = d;
    bus0.sel   = sl;
    bus0.cti   = ct;
    bus0.bte   = 2'b00;
    bus0.cyc   = 1'b1;
    bus0.stb   = 1'b1;
    wait_ack0(lat);
    rd = bus0.dat_r;
    e  = bus0.err;
    @(posedge clk); #1;
    check("gap", {30'b0, bus0.ack, bus0.err}, 32'h0);
    bus0.cyc = 1'b0;
    bus0.stb = 1'b0;
    bus0.we  = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, d;
    logic [3:0]  sl;
    logic [2:0]  ct;
    logic [6:0]  pat;
    logic [31:0] bd [4];
    logic        e, wr;
    int          lat, w;

    bus0.cyc = 0; bus0.stb = 0; bus0.we = 0;
    bus0.adr = 0; bus0.dat_w = 0; bus0.sel = 0;
    bus0.cti = 0; bus0.bte = 0;
    bus1.cyc = 0; bus1.stb = 0; bus1.we = 0;
    bus1.adr = 0; bus1.dat_w = 0; bus1.sel = 0;
    bus1.cti = 0; bus1.bte = 0;

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack0", bus0.ack, 0);
    check("rst_err0", bus0.err, 0);
    check("rst_dat0", bus0.dat_r, 0);
    check("rst_ack1", bus1.ack, 0);
    check("rst_dat1", bus1.dat_r, 0);
    rstn = 1'b1;
    mon  = 1'b1;
    @(posedge clk); #1;

    // byte-select merge
    classic(1, 4, 32'h11223344, 4'hF, 3'b000, rd, lat, e);
    check("w_lat", lat, 1);
    model[4] = 32'h11223344;
    classic(1, 4, 32'hAABBCCDD, 4'b0101, 3'b000, rd, lat, e);
    model[4] = merge(model[4], 32'hAABBCCDD, 4'b0101);
    classic(0, 4, 0, 4'hF, 3'b000, rd, lat, e);
    check("sel_merge", rd, 32'h11BB33DD);
    check("rd_lat", lat, 1);

    for (int i = 0; i < 24; i++) begin
      w = (i < 16) ? i : 1000 + i;
      d = $urandom;
      classic(1, w, d, 4'hF, 3'b000, rd, lat, e);
      model[w] = d;
    end

    for (int k = 0; k < 40; k++) begin
      w  = $urandom_range(0, 1) ? $urandom_range(0, 15)
                                : $urandom_range(1016, 1023);
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      sl = 4'($urandom_range(0, 15));
      ct = $urandom_range(0, 1) ? 3'b000 : 3'b111;
      classic(wr, w, d, sl, ct, rd, lat, e);
      check("rnd_lat", lat, 1);
      check("rnd_err", e, 0);
      if (wr) model[w] = merge(model[w], d, sl);
      else check("rnd_rd", rd, model[w]);
    end

    // STB held high: ACK every third cycle
    bus0.adr = 32'h10; bus0.we = 0; bus0.cti = 0;
    bus0.cyc = 1; bus0.stb = 1;
    pat = '0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      pat = {pat[5:0], bus0.ack};
    end
    bus0.cyc = 0; bus0.stb = 0;
    @(posedge clk); #1;
    check("b2b_pat", 32'(pat), 32'b1001001);

    d = $urandom;
    classic(1, 5, d, 4'hF, 3'b101, rd, lat, e);
    check("rsv_err", e, 1);
    check("rsv_lat", lat, 1);
    check("rsv_dat", rd, 0);
    classic(0, 5, 0, 4'hF, 3'b000, rd, lat, e);
    check("rsv_nowr", rd, model[5]);

    // CYC dropped during the ACK cycle
    bus0.adr = 32'h18; bus0.we = 1; bus0.sel = 4'hF;
    bus0.dat_w = ~model[6]; bus0.cti = 0;
    bus0.cyc = 1; bus0.stb = 1;
    wait_ack0(lat);
    check("cyc_lat", lat, 1);
    bus0.cyc = 0; bus0.stb = 0;
    @(posedge clk); #1;
    check("cyc_ack", bus0.ack, 0);
    bus0.we = 0;
    classic(0, 6, 0, 4'hF, 3'b000, rd, lat, e);
    check("cyc_nowr", rd, model[6]);

    // reset during the ACK cycle
    bus0.adr = 32'h18; bus0.we = 1; bus0.dat_w = ~model[6];
    bus0.cyc = 1; bus0.stb = 1;
    wait_ack0(lat);
    check("rstm_lat", lat, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rstm_ack", bus0.ack, 0);
    rstn = 1'b1;
    bus0.cyc = 0; bus0.stb = 0; bus0.we = 0;
    @(posedge clk); #1;
    classic(0, 6, 0, 4'hF, 3'b000, rd, lat, e);
    check("rstm_nowr", rd, model[6]);

`ifdef WB_SRAM_SLAVE_BURST_EN
    bus0.adr = 32'h0C; bus0.we = 0;
    bus0.cti = 3'b010; bus0.bte = 2'b01;
    bus0.cyc = 1; bus0.stb = 1;
    wait_ack0(lat);
    check("brd_lat", lat, 1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k == 3) bus0.cti = 3'b111;
      check("brd_ack", bus0.ack, 1);
      check("brd_dat", bus0.dat_r, model[wrap_word(3, k, 1)]);
    end
    @(posedge clk); #1;
    check("brd_done", bus0.ack, 0);
    bus0.cyc = 0; bus0.stb = 0;
    bus0.cti = 0; bus0.bte = 0;
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) bd[k] = $urandom;
    bus0.adr = 32'(1022 * 4); bus0.we = 1; bus0.sel = 4'hF;
    bus0.cti = 3'b010; bus0.bte = 2'b00; bus0.dat_w = bd[0];
    bus0.cyc = 1; bus0.stb = 1;
    wait_ack0(lat);
    check("bwr_lat", lat, 1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("bwr_ack", bus0.ack, 1);
      if (k < 4) bus0.dat_w = bd[k];
      else bus0.stb = 0;
    end
    @(posedge clk); #1;
    check("bwr_drop", bus0.ack, 0);
    bus0.cyc = 0; bus0.we = 0; bus0.cti = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) model[wrap_word(1022, k, 0)] = bd[k];
    for (int k = 0; k < 5; k++) begin
      w = wrap_word(1022, k, 0);
      classic(0, w, 0, 4'hF, 3'b000, rd, lat, e);
      check("bwr_mem", rd, model[w]);
    end
`else
    classic(0, 3, 0, 4'hF, 3'b010, rd, lat, e);
    check("incr_lat", lat, 1);
    check("incr_dat", rd, model[3]);
`endif

    // three wait states
    bus1.adr = 32'h1C; bus1.we = 1; bus1.sel = 4'hF;
    bus1.dat_w = 32'hCAFEF00D; bus1.cti = 0;
    bus1.cyc = 1; bus1.stb = 1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus1.ack && lat < 20);
    check("ws_wlat", lat, 4);
    @(posedge clk); #1;
    bus1.cyc = 0; bus1.stb = 0; bus1.we = 0;
    @(posedge clk); #1;
    bus1.cyc = 1; bus1.stb = 1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus1.ack && lat < 20);
    check("ws_rlat", lat, 4);
    check("ws_dat", bus1.dat_r, 32'hCAFEF00D);
    @(posedge clk); #1;
    check("ws_gap", bus1.ack, 0);
    bus1.cyc = 0; bus1.stb = 0;
    @(posedge clk); #1;

    mon = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
